// File: rtl/dmem_bank.sv
// dmem_bank: single-port data memory with a one-outstanding request/response
// handshake, byte-lane write strobes and a configurable response latency.
// Optional build macro DMEM_RANGE_CHECK_EN: flags word indices >= DEPTH with
// err_o, suppresses their writes and returns zero for their reads. Without it
// the word index wraps modulo DEPTH and err_o stays low.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready; a request is accepted and the array accessed here
// WAIT  | latency down-counter running, response held in resp_q
// RESP  | one-cycle response: rvalid_o high, rdata_o/err_o valid

module dmem_bank #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic                  rdy_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o
);

  localparam int NB      = DATA_W / 8;
  localparam int LANE_AW = $clog2(NB);
  localparam int WORD_AW = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   resp_q;
  logic                err_q;
  logic [ADDR_W-1:0]   word_full;
  logic [WORD_AW-1:0]  idx;
  logic                oor;
  logic                accept;
  logic [DATA_W-1:0]   fresh;
  logic                addr_unused;

  // Byte lanes below word granularity are ignored by design; the reduction
  // keeps every address bit referenced in both build variants.
  assign addr_unused = ^addr_i;

  assign word_full = addr_i >> LANE_AW;
  assign idx       = word_full[WORD_AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign oor = (word_full >= ADDR_W'(DEPTH));
`else
  assign oor = 1'b0;
`endif

  assign rdy_o    = (state_q == IDLE);
  assign accept   = req_i && rdy_o && !rst;
  assign rvalid_o = (state_q == RESP);
  assign err_o    = (state_q == RESP) && err_q;

  // Response word for the request currently presented: writes answer zero,
  // out-of-range reads answer zero.
  always_comb begin
    fresh = '0;
    if (!we_i && !oor) fresh = mem[idx];
  end

  // Array write at the acceptance edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && we_i && !oor) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Next-state and latency down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and response registers; rdata_o only changes on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      rdata_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        resp_q <= fresh;
        err_q  <= oor;
      end
      if (state_d == RESP) rdata_o <= accept ? fresh : resp_q;
    end
  end

endmodule

// File: doc/dmem_bank.md
# dmem_bank

Parametrised single-port data memory with a request/response handshake, byte-lane write strobes and a configurable access latency. It replaces the fixed 32-bit combinational-read memory in the peripheral space. The core's load/store unit talks to it through a one-outstanding-transaction interface, so slower memory timing can be modelled without changing the core.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 32, byte-address width.
- DEPTH, 1024, number of words; power of two.
- LATENCY, 1, cycles from acceptance to response; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_W  byte address; word index = addr_i[log2(DEPTH)+1:2] (DATA_W=32 lane math; generally addr_i >> log2(DATA_W/8)).
- wdata_i  in  DATA_W  write data.
- be_i  in  DATA_W/8  byte-lane write enables.
- rdy_o  out  1  block can accept a request this cycle.
- rvalid_o  out  1  one-cycle response pulse.
- rdata_o  out  DATA_W  read data, valid when rvalid_o=1.
- err_o  out  1  response error flag, valid with rvalid_o.

## Operation
- FSM states: IDLE, WAIT, RESP.
- rdy_o = (state==IDLE), combinational from state only.
- Acceptance: a request is accepted at a clock edge where req_i=1 and rdy_o=1. req_i is ignored in other states and is not queued.
- At the acceptance edge, the array access executes:
  - Write: each lane k with be_i[k]=1 is updated from wdata_i[8k+7:8k]. Other lanes are unchanged. be_i=0 is a legal no-op that is still acknowledged.
  - Read: the full word is captured into the response register. be_i is ignored.
- Transitions:
  - IDLE→RESP if accepted and LATENCY=1.
  - IDLE→WAIT if accepted and LATENCY>1; cnt loaded with LATENCY-2.
  - In WAIT, cnt decrements. When cnt=0, WAIT→RESP.
  - RESP→IDLE unconditionally.
- Outputs in RESP:
  - rvalid_o=1.
  - rdata_o = captured word for a read.
  - rdata_o on a write = 0.
  - err_o per the range check (see Configuration).
- Outside RESP: rvalid_o=0, err_o=0, rdata_o holds its last value.
- Back-to-back transactions: a read accepted after a write completes returns the written data. There is no read-during-write hazard because only one transaction is outstanding.
- Low address bits below word granularity are ignored; misaligned addresses are not flagged.
- Array contents are not reset.

## Timing
- Reset values: state=IDLE, cnt=0, rvalid_o=0, rdata_o=0, err_o=0, rdy_o=1 (follows from state=IDLE).
- rst asserted mid-transaction:
  - The pending response is dropped and no rvalid_o pulse is produced.
  - A write committed at its acceptance edge remains in the array.
- Acceptance at edge T0 gives rvalid_o=1 for exactly the cycle following edge T0+LATENCY-1. That is, the pulse is LATENCY cycles after the accepting cycle.
- rdy_o returns high the cycle after RESP.
- Throughput: one transaction per LATENCY+1 cycles.
- If req_i is held high continuously, a new request is accepted on every IDLE cycle.

## Configuration
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - A word index ≥ DEPTH (computed from the full addr_i) is out of range.
  - Out-of-range writes do not modify the array.
  - Out-of-range reads return rdata_o=0.
  - The response carries err_o=1; latency is unchanged.
- Undefined:
  - The address is taken modulo DEPTH (upper bits ignored).
  - err_o is tied to 0.

## Test plan
- Reset: hold rst 3 cycles mid-WAIT (LATENCY=3) → no rvalid_o pulse, rdy_o=1, rdata_o=0, err_o=0 after release.
- Full write/read, LATENCY=1: write 0xDEADBEEF @0x10 with be=0xF, then read @0x10 → write response has rdata_o=0; read rvalid_o the cycle after acceptance with rdata_o=0xDEADBEEF.
- Byte lanes: preload 0x11223344 @0x20, write 0xAABBCCDD with be=0x5, read → 0x11BB33DD. A be=0x0 write is acked and the word is unchanged.
- Latency/handshake, LATENCY=4: req_i held high with 3 reads → each rvalid_o exactly 4 cycles after acceptance, accepts 5 cycles apart, rdy_o low in WAIT/RESP.
- Range, DEPTH=1024:
  - With DMEM_RANGE_CHECK_EN: write 0x55 @0x1000, then read @0x1000 → both responses err_o=1, read data 0, word @0x0 unchanged.
  - Without the macro: the same sequence gives err_o=0 and a read @0x0 returns 0x55.
- Reset during RESP: assert rst in the rvalid_o cycle → rvalid_o=0 next cycle, and a subsequent read returns the previously committed write data.
